// File: rtl/flag_unit_pkg.sv
// Shared constants for the flag unit: opcodes, flag indices, default width.
package flag_unit_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRA = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;

    // Bit positions inside the packed flag vector
    localparam int FLG_Z     = 0;
    localparam int FLG_V     = 1;
    localparam int FLG_N     = 2;
    localparam int NUM_FLAGS = 3;

    // True for any opcode that writes at least one flag
    function automatic logic is_setter(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
               (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/flag_unit_flag_calc.sv
// Combinational flag values and per-flag update mask for the EX instruction.
module flag_calc
    import flag_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [3:0]           i_opcode,
    input  logic [WIDTH-1:0]     i_alu_a,
    input  logic [WIDTH-1:0]     i_alu_b,
    input  logic [WIDTH-1:0]     i_alu_result,
    output logic [NUM_FLAGS-1:0] o_new_flags,
    output logic [NUM_FLAGS-1:0] o_upd_mask
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_raw_sum;
    logic             w_ovf;

    // Overflow comes from the raw wrapped sum; the ALU result may be saturated
    always_comb begin
        w_b_eff   = (i_opcode == OP_SUB) ? (~i_alu_b + {{(WIDTH-1){1'b0}}, 1'b1}) : i_alu_b;
        w_raw_sum = i_alu_a + w_b_eff;
        w_ovf     = (i_alu_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                    (w_raw_sum[WIDTH-1] != i_alu_a[WIDTH-1]);
    end

    // Z and N come from the final result; mask selects which flags this class writes
    always_comb begin
        o_new_flags         = '0;
        o_new_flags[FLG_Z]  = (i_alu_result == '0);
        o_new_flags[FLG_V]  = w_ovf;
        o_new_flags[FLG_N]  = i_alu_result[WIDTH-1];
        o_upd_mask          = '0;
        case (i_opcode)
            OP_ADD, OP_SUB: o_upd_mask = '1;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: o_upd_mask[FLG_Z] = 1'b1;
            default: o_upd_mask = '0;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag register with branch flag-hazard stall generation.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             hold,
    input  logic             id_is_branch,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             flag_stall
);

    logic [NUM_FLAGS-1:0] r_flags;
    logic                 r_stall_d;
    logic [NUM_FLAGS-1:0] w_new_flags;
    logic [NUM_FLAGS-1:0] w_upd_mask;
    logic                 w_commit;

    flag_calc #(.WIDTH(WIDTH)) u_calc (
        .i_opcode     (ex_opcode),
        .i_alu_a      (alu_a),
        .i_alu_b      (alu_b),
        .i_alu_result (alu_result),
        .o_new_flags  (w_new_flags),
        .o_upd_mask   (w_upd_mask)
    );

    assign w_commit = ex_valid & ~hold;

    // Stall the branch in ID while a setter is about to commit; stall_d stops a
    // second stall when the same setter lingers in EX. Forced low during reset.
    always_comb begin
        flag_stall = rst_n & id_is_branch & ex_valid & is_setter(ex_opcode) &
                     ~hold & ~r_stall_d;
    end

    // Flag register: only flags in the opcode's class load, the rest hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_commit) begin
            r_flags <= (r_flags & ~w_upd_mask) | (w_new_flags & w_upd_mask);
        end
    end

    // One-cycle delayed copy of the stall request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_d <= 1'b0;
        end else begin
            r_stall_d <= flag_stall;
        end
    end

    assign flag_z = r_flags[FLG_Z];
    assign flag_v = r_flags[FLG_V];
    assign flag_n = r_flags[FLG_N];

endmodule
